// File: rtl/painterengine_gpu_pkg.sv
// rtl/painterengine_gpu_pkg.sv - shared state encodings and AXI codes for the gpu reader
package painterengine_gpu_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_CALC,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN,
    ST_DONE,
    ST_ERROR
  } reader_state_t;

  localparam int         DEFAULT_MAX_BURST = 16;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B       = 3'b010;

endpackage

// File: rtl/painterengine_gpu_reader_burstcalc.sv
// rtl/painterengine_gpu_reader_burstcalc.sv - beats in next burst: min(remaining, MAX_BURST, words left in 4 KB page)
module painterengine_gpu_reader_burstcalc
  import painterengine_gpu_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic [31:0] remaining,
  input  logic [9:0]  word_offset,
  output logic [8:0]  burst
);

  logic [10:0] page_room;

  always_comb begin
    // 1..1024 words until the next 4 KB boundary
    page_room = 11'd1024 - {1'b0, word_offset};
    burst     = 9'(MAX_BURST);
    if ({21'd0, page_room} < 32'(MAX_BURST)) begin
      burst = page_room[8:0];
    end
    if (remaining < {23'd0, burst}) begin
      burst = remaining[8:0];
    end
  end

endmodule

// File: rtl/painterengine_gpu_reader.sv
// rtl/painterengine_gpu_reader.sv - AXI4 read master streaming a word buffer to the display engine
module painterengine_gpu_reader
  import painterengine_gpu_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic [31:0] i_wire_address,
  input  logic [31:0] i_wire_length,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [31:0] o_wire_data,
  output logic        o_wire_data_valid,
  input  logic        i_wire_data_next,
  output logic [31:0] o_wire_araddr,
  output logic [7:0]  o_wire_arlen,
  output logic [2:0]  o_wire_arsize,
  output logic [1:0]  o_wire_arburst,
  output logic        o_wire_arvalid,
  input  logic        i_wire_arready,
  input  logic [31:0] i_wire_rdata,
  input  logic [1:0]  i_wire_rresp,
  input  logic        i_wire_rlast,
  input  logic        i_wire_rvalid,
  output logic        o_wire_rready
);

  reader_state_t state;
  logic          init_latched;
  logic [31:0]   remaining;
  logic [31:0]   cur_addr;
  logic [8:0]    burst;
  logic [8:0]    beat_cnt;
  logic [8:0]    calc_burst;
  logic          beat;
  logic          last_beat;
  logic          beat_ok;

  painterengine_gpu_reader_burstcalc #(
    .MAX_BURST(MAX_BURST)
  ) u_burstcalc (
    .remaining  (remaining),
    .word_offset(cur_addr[11:2]),
    .burst      (calc_burst)
  );

  assign o_wire_arsize  = AXI_SIZE_4B;
  assign o_wire_arburst = AXI_BURST_INCR;

  // R channel is a pure pass-through so the pixel word costs no latency
  always_comb begin
    o_wire_rready     = (state == ST_DATA) ? i_wire_data_next : (state == ST_DRAIN);
    beat              = i_wire_rvalid && o_wire_rready;
    last_beat         = (beat_cnt == burst - 9'd1);
    beat_ok           = (i_wire_rresp == AXI_RESP_OKAY) && (i_wire_rlast == last_beat);
    o_wire_data_valid = (state == ST_DATA) && beat && beat_ok;
    o_wire_data       = o_wire_data_valid ? i_wire_rdata : 32'd0;
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state          <= ST_INIT;
      init_latched   <= 1'b0;
      remaining      <= 32'd0;
      cur_addr       <= 32'd0;
      burst          <= 9'd0;
      beat_cnt       <= 9'd0;
      o_wire_done    <= 1'b0;
      o_wire_error   <= 1'b0;
      o_wire_arvalid <= 1'b0;
      o_wire_araddr  <= 32'd0;
      o_wire_arlen   <= 8'd0;
    end else begin
      case (state)
        ST_INIT: begin
          if (!init_latched) begin
            remaining    <= i_wire_length;
            cur_addr     <= i_wire_address;
            init_latched <= 1'b1;
          end else if (remaining == 32'd0) begin
            state       <= ST_DONE;
            o_wire_done <= 1'b1;
          end else if (cur_addr[1:0] != 2'b00) begin
            state        <= ST_ERROR;
            o_wire_error <= 1'b1;
          end else begin
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          burst          <= calc_burst;
          beat_cnt       <= 9'd0;
          o_wire_araddr  <= cur_addr;
          o_wire_arlen   <= 8'(calc_burst - 9'd1);
          o_wire_arvalid <= 1'b1;
          state          <= ST_ADDR;
        end
        ST_ADDR: begin
          if (i_wire_arready) begin
            o_wire_arvalid <= 1'b0;
            state          <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (beat) begin
            if (!beat_ok) begin
              o_wire_error <= 1'b1;
              state        <= i_wire_rlast ? ST_ERROR : ST_DRAIN;
            end else begin
              remaining <= remaining - 32'd1;
              beat_cnt  <= beat_cnt + 9'd1;
              if (last_beat) begin
                cur_addr <= cur_addr + {21'd0, burst, 2'b00};
                if (remaining == 32'd1) begin
                  state       <= ST_DONE;
                  o_wire_done <= 1'b1;
                end else begin
                  state <= ST_CALC;
                end
              end
            end
          end
        end
        ST_DRAIN: begin
          if (i_wire_rvalid && i_wire_rlast) begin
            state <= ST_ERROR;
          end
        end
        ST_DONE:  state <= ST_DONE;
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_reader.sv
// tb/tb_painterengine_gpu_reader.sv - randomized AXI slave and word-level reference model for the gpu reader
module tb_painterengine_gpu_reader;

  localparam int MAXB = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] length = 32'd0;
  logic        done, error, data_valid;
  logic [31:0] data;
  logic        data_next = 1'b1;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'b00;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  always #5 clk = ~clk;

  painterengine_gpu_reader #(.MAX_BURST(MAXB)) dut (
    .i_wire_clock(clk), .i_wire_resetn(resetn), .i_wire_address(address), .i_wire_length(length),
    .o_wire_done(done), .o_wire_error(error), .o_wire_data(data), .o_wire_data_valid(data_valid),
    .i_wire_data_next(data_next), .o_wire_araddr(araddr), .o_wire_arlen(arlen), .o_wire_arsize(arsize),
    .o_wire_arburst(arburst), .o_wire_arvalid(arvalid), .i_wire_arready(arready), .i_wire_rdata(rdata),
    .i_wire_rresp(rresp), .i_wire_rlast(rlast), .i_wire_rvalid(rvalid), .o_wire_rready(rready)
  );

  int checks = 0;
  int errors = 0;

  int cfg_ar_delay_max = 0, cfg_next_mode = 0, cfg_err_beat = 0;
  bit cfg_force_r = 0, mon_en = 0;

  bit          b_active = 0;
  logic [31:0] b_addr = 32'd0;
  int          b_left = 0, beat_no = 0, ar_wait = 0, ar_delay = 0;
  bit          hs_ar_q = 0, hs_r_q = 0;
  logic [31:0] ar_addr_q = 32'd0;
  logic [7:0]  ar_len_q = 8'd0;

  logic [31:0] got_words[$];
  logic [31:0] got_ar_addr[$];
  int          got_ar_len[$];
  logic [31:0] exp_words[$];
  logic [31:0] exp_ar_addr[$];
  int          exp_ar_len[$];
  int arvalid_cycles, drained, ar_unstable, ar_withdrawn, rready_bad, overlap, both_bad, valid_bad, bad_attr;
  bit          prev_wait = 0;
  logic [31:0] prev_addr = 32'd0;
  logic [7:0]  prev_len = 8'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Monitor: everything sampled mid-cycle, describes what the DUT sees at the next rising edge
  always @(negedge clk) begin
    hs_ar_q   = arvalid && arready;
    hs_r_q    = rvalid && rready;
    ar_addr_q = araddr;
    ar_len_q  = arlen;
    if (mon_en) begin
      if (arvalid) arvalid_cycles++;
      if (hs_ar_q) begin
        got_ar_addr.push_back(araddr);
        got_ar_len.push_back(int'(arlen));
        if (b_active) overlap++;
        if (arsize !== 3'b010 || arburst !== 2'b01) bad_attr++;
      end
      if (prev_wait && (araddr !== prev_addr || arlen !== prev_len)) ar_unstable++;
      if (prev_wait && !arvalid) ar_withdrawn++;
      prev_wait = arvalid && !arready;
      prev_addr = araddr;
      prev_len  = arlen;
      if (data_valid) begin
        got_words.push_back(data);
        if (!hs_r_q) valid_bad++;
      end else if (hs_r_q) begin
        drained++;
      end
      if (b_active && cfg_err_beat == 0 && rready !== data_next) rready_bad++;
      if (done && error) both_bad++;
    end
  end

  // AXI slave over a synthetic memory, plus downstream next pattern
  always @(posedge clk) begin
    #1;
    if (!resetn) begin
      b_active = 0; beat_no = 0; ar_wait = 0; arready = 1'b0;
      rvalid = cfg_force_r; rlast = cfg_force_r; rresp = 2'b00;
      rdata = cfg_force_r ? 32'hDEAD_BEEF : 32'd0;
      data_next = 1'b1;
    end else begin
      if (b_active && hs_r_q) begin
        b_addr += 32'd4; b_left--; beat_no++;
        if (b_left == 0) b_active = 0;
      end
      if (hs_ar_q && !b_active) begin
        b_active = 1; b_addr = ar_addr_q; b_left = int'(ar_len_q) + 1;
        arready = 1'b0; ar_wait = 0; ar_delay = $urandom_range(0, cfg_ar_delay_max);
      end else if (arvalid && !arready && !b_active) begin
        if (ar_wait >= ar_delay) arready = 1'b1;
        else ar_wait++;
      end
      if (b_active) begin
        rvalid = 1'b1; rdata = mem_word(b_addr); rlast = (b_left == 1);
        rresp = (cfg_err_beat != 0 && beat_no + 1 == cfg_err_beat) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0; rdata = 32'd0; rlast = 1'b0; rresp = 2'b00;
      end
      case (cfg_next_mode)
        1:       data_next = ~data_next;
        2:       data_next = 1'($urandom_range(0, 1));
        default: data_next = 1'b1;
      endcase
    end
  end

  task automatic model_job(input logic [31:0] a0, input int len);
    logic [31:0] a;
    int rem, n, room;
    exp_words.delete(); exp_ar_addr.delete(); exp_ar_len.delete();
    for (int i = 0; i < len; i++) exp_words.push_back(mem_word(a0 + 32'(4 * i)));
    a = a0; rem = len;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      n = rem;
      if (n > MAXB) n = MAXB;
      if (n > room) n = room;
      exp_ar_addr.push_back(a);
      exp_ar_len.push_back(n - 1);
      a += 32'(4 * n);
      rem -= n;
    end
  endtask

  task automatic start_job(input logic [31:0] a, input int len, input int dmax, input int mode, input int errb);
    @(posedge clk); #3;
    resetn = 1'b0; address = a; length = 32'(len);
    cfg_ar_delay_max = dmax; cfg_next_mode = mode; cfg_err_beat = errb; cfg_force_r = 0;
    ar_delay = $urandom_range(0, dmax);
    repeat (2) @(posedge clk);
    #3;
    got_words.delete(); got_ar_addr.delete(); got_ar_len.delete();
    arvalid_cycles = 0; drained = 0; ar_unstable = 0; ar_withdrawn = 0; rready_bad = 0;
    overlap = 0; both_bad = 0; valid_bad = 0; bad_attr = 0; prev_wait = 0;
    mon_en = 1; resetn = 1'b1;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!((done || error) && !b_active) && n < 4000) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!(done || error)) begin
      errors++; $display("FAIL %s timeout: done=%0b error=%0b after %0d cycles, required completion", name, done, error, n);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0; cfg_force_r = 1; arready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({done, error, arvalid, rready, data_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b required 00000", {done, error, arvalid, rready, data_valid});
    end
    checks++;
    if (araddr !== 32'd0 || arlen !== 8'd0) begin
      errors++; $display("FAIL reset_ar got araddr=%h arlen=%0d required 0/0", araddr, arlen);
    end
    checks++;
    if (data !== 32'd0) begin
      errors++; $display("FAIL reset_data got %h required 0", data);
    end
    cfg_force_r = 0; arready = 1'b0;
  endtask

  task automatic test_multi_burst;
    model_job(32'h1000, 40);
    start_job(32'h1000, 40, 0, 0, 0);
    wait_end("multi_burst");
    checks++;
    if (got_ar_addr.size() != 3 || got_ar_len.size() != 3) begin
      errors++; $display("FAIL mb_ar_count got %0d required 3", got_ar_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_ar_addr[i] !== exp_ar_addr[i] || got_ar_len[i] != exp_ar_len[i]) begin
          errors++; $display("FAIL mb_ar[%0d] got %h/%0d required %h/%0d", i, got_ar_addr[i], got_ar_len[i], exp_ar_addr[i], exp_ar_len[i]);
        end
      end
    end
    checks++;
    if (got_words.size() != 40) begin
      errors++; $display("FAIL mb_word_count got %0d required 40", got_words.size());
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (got_words[i] !== exp_words[i]) begin
          errors++; $display("FAIL mb_word[%0d] got %h required %h", i, got_words[i], exp_words[i]);
        end
      end
    end
    checks++;
    if ({done, error} !== 2'b10 || bad_attr != 0 || valid_bad != 0) begin
      errors++; $display("FAIL mb_status got done=%0b error=%0b attr=%0d vbad=%0d required 1/0/0/0", done, error, bad_attr, valid_bad);
    end
  endtask

  task automatic test_page_cross;
    model_job(32'h0FF0, 8);
    start_job(32'h0FF0, 8, 0, 0, 0);
    wait_end("page_cross");
    checks++;
    if (got_ar_addr.size() != 2) begin
      errors++; $display("FAIL pc_ar_count got %0d required 2", got_ar_addr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_ar_addr[i] !== exp_ar_addr[i] || got_ar_len[i] != exp_ar_len[i]) begin
          errors++; $display("FAIL pc_ar[%0d] got %h/%0d required %h/%0d", i, got_ar_addr[i], got_ar_len[i], exp_ar_addr[i], exp_ar_len[i]);
        end
      end
    end
    checks++;
    if (got_words != exp_words || done !== 1'b1) begin
      errors++; $display("FAIL pc_words got count=%0d done=%0b required count=8 done=1", got_words.size(), done);
    end
  endtask

  task automatic test_zero_len;
    start_job(32'h1000, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL zl_early got done=%0b required 0 one cycle after release", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL zl_done got done=%0b error=%0b required 1/0 two cycles after release", done, error);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (arvalid_cycles != 0) begin
      errors++; $display("FAIL zl_arvalid got %0d arvalid cycles required 0", arvalid_cycles);
    end
  endtask

  task automatic test_misaligned;
    start_job(32'h2002, 4, 0, 0, 0);
    wait_end("misaligned");
    checks++;
    if ({done, error} !== 2'b01 || arvalid_cycles != 0 || got_ar_addr.size() != 0) begin
      errors++; $display("FAIL ma_status got done=%0b error=%0b arvalid=%0d ar=%0d required 0/1/0/0", done, error, arvalid_cycles, got_ar_addr.size());
    end
  endtask

  task automatic test_slverr;
    model_job(32'h3000, 16);
    start_job(32'h3000, 16, 0, 0, 5);
    wait_end("slverr");
    checks++;
    if (got_words.size() != 4) begin
      errors++; $display("FAIL se_word_count got %0d required 4", got_words.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_words[i] !== exp_words[i]) begin
          errors++; $display("FAIL se_word[%0d] got %h required %h", i, got_words[i], exp_words[i]);
        end
      end
    end
    checks++;
    if (drained != 12) begin
      errors++; $display("FAIL se_drained got %0d required 12", drained);
    end
    checks++;
    if ({done, error} !== 2'b01 || both_bad != 0 || got_ar_addr.size() != 1) begin
      errors++; $display("FAIL se_status got done=%0b error=%0b both=%0d ar=%0d required 0/1/0/1", done, error, both_bad, got_ar_addr.size());
    end
  endtask

  task automatic test_backpressure;
    model_job(32'h5000, 16);
    start_job(32'h5000, 16, 5, 1, 0);
    wait_end("backpressure");
    checks++;
    if (rready_bad != 0) begin
      errors++; $display("FAIL bp_rready got %0d cycles rready!=next required 0", rready_bad);
    end
    checks++;
    if (ar_unstable != 0 || ar_withdrawn != 0) begin
      errors++; $display("FAIL bp_ar_hold got unstable=%0d withdrawn=%0d required 0/0", ar_unstable, ar_withdrawn);
    end
    checks++;
    if (got_words != exp_words || done !== 1'b1) begin
      errors++; $display("FAIL bp_words got count=%0d done=%0b required 16/1", got_words.size(), done);
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    int len;
    for (int j = 0; j < 6; j++) begin
      a = 32'h0001_0000 + 32'($urandom_range(0, 7)) * 32'd4096 + 32'($urandom_range(900, 1023)) * 32'd4;
      len = $urandom_range(1, 60);
      model_job(a, len);
      start_job(a, len, $urandom_range(0, 3), 2, 0);
      wait_end("random");
      checks++;
      if (got_ar_addr != exp_ar_addr || got_ar_len != exp_ar_len) begin
        errors++; $display("FAIL rnd%0d_bursts addr=%h len=%0d got %0d bursts required %0d", j, a, len, got_ar_addr.size(), exp_ar_addr.size());
      end
      checks++;
      if (got_words != exp_words) begin
        errors++; $display("FAIL rnd%0d_words addr=%h got %0d words required %0d", j, a, got_words.size(), len);
      end
      checks++;
      if ({done, error} !== 2'b10 || overlap != 0 || rready_bad != 0 || ar_unstable != 0 || valid_bad != 0) begin
        errors++; $display("FAIL rnd%0d_protocol got done=%0b error=%0b ovl=%0d rr=%0d unst=%0d vb=%0d required 1/0/0/0/0/0",
                           j, done, error, overlap, rready_bad, ar_unstable, valid_bad);
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    int n, cnt;
    start_job(32'h6000, 32, 0, 0, 0);
    n = 0;
    while (got_words.size() < 5 && n < 200) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    checks++;
    if ({arvalid, rready, data_valid, done, error} !== 5'b0 || data !== 32'd0) begin
      errors++; $display("FAIL mid_reset got arv=%0b rr=%0b dv=%0b done=%0b err=%0b data=%h required all 0",
                         arvalid, rready, data_valid, done, error, data);
    end
    cnt = got_words.size();
    repeat (5) @(negedge clk);
    checks++;
    if (got_words.size() != cnt || cnt < 5) begin
      errors++; $display("FAIL mid_reset_quiet got %0d words required %0d unchanged (>=5)", got_words.size(), cnt);
    end
  endtask

  initial begin
    test_reset;
    test_multi_burst;
    test_page_cross;
    test_zero_len;
    test_misaligned;
    test_slverr;
    test_backpressure;
    test_random;
    test_reset_mid_burst;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
